x25519_request_engine: RTL

- Host-side sequencer that drives the X25519 scalar-multiplication core (en / work_in / e in, out_valid / work_out out).
- Accepts a key-exchange request over a valid/ready handshake, applies RFC 7748 scalar clamping and u-coordinate masking, and pulses the core start.
- Waits for the core result under a timeout, checks for the all-zero (non-contributory) shared secret, and returns the result over a valid/ready response channel.

---
 rtl/x25519_request_engine.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/x25519_request_engine.sv
// rtl/x25519_request_engine.sv - host-side request sequencer for an X25519 scalar-multiplication core
//
// Purpose:
//   Accepts one key-exchange request at a time and clamps the scalar and masks
//   the u-coordinate as RFC 7748 requires. It starts the core with a one-cycle
//   pulse and waits for the result under a timeout. The result goes out on a
//   valid/ready response channel, flagged if it is the all-zero
//   (non-contributory) shared secret.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req_valid/req_ready         request handshake
//   req_mode                    0 = shared secret with req_point, 1 = public key from BASE_POINT
//   req_scalar, req_point       private scalar and peer u-coordinate (bit 0 = LSB)
//   core_en                     one-cycle start pulse to the core
//   core_work_in, core_e        masked u-coordinate and clamped scalar, held until next accept
//   core_out_valid, core_work_out  core result strobe and value
//   rsp_valid/rsp_ready         response handshake
//   rsp_data                    result u-coordinate (0 on timeout)
//   rsp_zero                    result was all-zero
//   rsp_timeout                 core did not answer in time
//   busy                        engine is not idle
module x25519_request_engine #(
  parameter int unsigned  TIMEOUT_CYCLES = 65536,
  parameter logic [255:0] BASE_POINT     = 256'd9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_mode,
  input  logic [255:0] req_scalar,
  input  logic [255:0] req_point,
  output logic         core_en,
  output logic [255:0] core_work_in,
  output logic [255:0] core_e,
  input  logic         core_out_valid,
  input  logic [255:0] core_work_out,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [255:0] rsp_data,
  output logic         rsp_zero,
  output logic         rsp_timeout,
  output logic         busy
);

  // Counter only has to reach TIMEOUT_CYCLES-1, so clog2 bits are enough.
  localparam int unsigned   CW         = $clog2(TIMEOUT_CYCLES);
  // Expiry is detected on the cycle whose increment would reach TIMEOUT_CYCLES-1,
  // so the response appears exactly TIMEOUT_CYCLES cycles after core_en.
  localparam logic [CW-1:0] CNT_EXPIRE = CW'(TIMEOUT_CYCLES - 2);

  // Clamping: clear bits [2:0] and 255, set bit 254.
  localparam logic [255:0]  CLAMP_KEEP = {2'b00, {251{1'b1}}, 3'b000};
  localparam logic [255:0]  CLAMP_SET  = {2'b01, 254'd0};
  // u-coordinate masking: clear bit 255.
  localparam logic [255:0]  U_MASK     = {1'b0, {255{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        state_q;
  logic          stale_q;
  logic [CW-1:0] cnt_q;
  logic          core_en_q;
  logic [255:0]  work_in_q;
  logic [255:0]  e_q;
  logic          rsp_valid_q;
  logic [255:0]  rsp_data_q;
  logic          rsp_zero_q;
  logic          rsp_timeout_q;

  logic [255:0]  point_sel;

  // While stale is set, the core may still be finishing an abandoned job, so no
  // new request is taken until its late result has been drained.
  assign req_ready = (state_q == S_IDLE) && !stale_q && !rst;
  assign busy      = (state_q != S_IDLE);

  assign point_sel = req_mode ? BASE_POINT : req_point;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      stale_q       <= 1'b0;
      cnt_q         <= '0;
      core_en_q     <= 1'b0;
      work_in_q     <= '0;
      e_q           <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_zero_q    <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      core_en_q <= 1'b0;

      // A result outside WAIT can only be the late answer of an abandoned job.
      if (core_out_valid && (state_q != S_WAIT)) begin
        stale_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            e_q       <= (req_scalar & CLAMP_KEEP) | CLAMP_SET;
            work_in_q <= point_sel & U_MASK;
            core_en_q <= 1'b1;
            state_q   <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end

        S_WAIT: begin
          cnt_q <= cnt_q + CW'(1);
          // A result arriving on the expiry cycle takes priority over the timeout.
          if (core_out_valid) begin
            rsp_data_q    <= core_work_out;
            rsp_zero_q    <= (core_work_out == 256'd0);
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state_q       <= S_RESP;
          end else if (cnt_q == CNT_EXPIRE) begin
            rsp_data_q    <= '0;
            rsp_zero_q    <= 1'b0;
            rsp_timeout_q <= 1'b1;
            rsp_valid_q   <= 1'b1;
            stale_q       <= 1'b1;
            state_q       <= S_RESP;
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign core_en      = core_en_q;
  assign core_work_in = work_in_q;
  assign core_e       = e_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_timeout  = rsp_timeout_q;

endmodule
